router_pkt_rx: RTL and testbench
================================

# router_pkt_rx

Parametrised packet receiver for the router's source port. It accepts byte-serial packets from the source interface (pkt_valid / data_in / busy / err) and parses the header for destination and length. It steers every byte into one of NUM_CH destination FIFOs, checks the parity byte and flags errors. It also detects truncated and misaddressed packets, and keeps saturating good-packet and error counters. It supersedes the fixed 3-channel, 8-bit input FSM.

## Interface
- DATA_W, default 8: byte width of data_in and wr_data; minimum 4.
- NUM_CH, default 3: number of destination channels; range 2..2**(DATA_W-2).
- CNT_W, default 16: width of each statistics counter.
- Derived: ADDR_W = max(1, clog2(NUM_CH)); LEN_W = DATA_W - ADDR_W.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pkt_valid  in  1  source asserts for every byte of a packet, header through parity byte inclusive.
- data_in  in  DATA_W  packet byte.
- fifo_full  in  NUM_CH  per-channel destination FIFO full.
- busy  out  1  combinational; source must hold data_in while high.
- err  out  1  one-cycle error pulse (registered).
- wr_en  out  NUM_CH  one-hot FIFO write strobe (combinational).
- wr_data  out  DATA_W  equals data_in.
- good_cnt  out  CNT_W  packets completed with correct parity; saturates at all-ones.
- err_cnt  out  CNT_W  error events; saturates at all-ones.

## Operation
- Packet format: header byte with dest = hdr[ADDR_W-1:0] and len = hdr[DATA_W-1:ADDR_W]. The header is followed by len payload bytes and then one parity byte. Parity = XOR of the header and all payload bytes.
- Transfer: a byte is accepted at a rising edge when pkt_valid=1 and busy=0. No gaps are allowed inside a packet.
- States and transitions:
  - IDLE, accepted byte with dest < NUM_CH: write the header to FIFO dest, latch dest, load remaining = len, set parity register = header. Go to PAYLOAD if len > 0, otherwise PARITY.
  - IDLE, accepted byte with dest >= NUM_CH: write nothing, set err=1, increment err_cnt, go to DROP.
  - PAYLOAD, accepted byte: write it to FIFO dest, XOR it into the parity register, decrement remaining. Go to PARITY when remaining reaches 0.
  - PARITY, accepted byte: write it to FIFO dest and go to CHECK.
    - If the byte is not equal to the parity register: err=1, err_cnt+1.
    - Otherwise: good_cnt+1.
  - PAYLOAD/PARITY, pkt_valid=0 while busy=0 (truncation): err=1, err_cnt+1, go to CHECK. Bytes already written stay in the FIFO.
  - CHECK: single cycle with busy=1; then go to IDLE.
  - DROP: bytes are consumed with busy=0 and never written. Return to IDLE at the first edge where pkt_valid=0.
- busy = rst, or CHECK, or (IDLE and pkt_valid and dest of data_in < NUM_CH and fifo_full[that dest]), or (PAYLOAD/PARITY and fifo_full[latched dest]).
- wr_en[dest] = accept and state in {IDLE with valid dest, PAYLOAD, PARITY}; all other wr_en bits are 0.
- Counter arithmetic: CNT_W-bit unsigned with saturation; an increment at all-ones holds the value.

## Timing
- Reset values: state=IDLE, err=0, good_cnt=0, err_cnt=0. While rst=1, busy=1 and wr_en=0.
- Reset mid-packet: the packet is abandoned. No err pulse and no counter update; the FIFO contents are not the block's concern.
- Write latency is zero: wr_en and wr_data are valid in the same cycle the byte is accepted.
- err is high for exactly the one cycle after the edge that detects the error. For parity and truncation errors this is the CHECK cycle. Counters update at that same edge.
- Minimum packet (len=0) takes header + parity + CHECK = 3 cycles. The next header may be presented in the cycle after CHECK.
- fifo_full rising mid-packet stalls transfer. busy follows fifo_full in the same cycle, and the byte is held and accepted once fifo_full falls.
- err remains a single-cycle pulse for any error.

## Test plan
- Good packet, NUM_CH=3: header 0x11 (dest 1, len 4), payload 0xA1 0xB2 0xC3 0xD4, correct parity byte -> wr_en=3'b010 for 6 cycles, busy=1 only in CHECK, err=0, good_cnt=1.
- Same packet with parity byte XORed with 0x01 -> all 6 bytes written, err=1 in the CHECK cycle, err_cnt=1, good_cnt=0.
- fifo_full[2] held high for 3 cycles at payload byte 2 of a dest-2 packet -> busy=1 for exactly those 3 cycles, no wr_en, byte written on release, parity still correct.
- Header dest=3 with NUM_CH=3, 5 bytes under pkt_valid -> no wr_en at all, err pulse one cycle after the header edge, back to IDLE after pkt_valid falls, err_cnt=1.
- pkt_valid dropped after 2 of 4 payload bytes -> err pulse, CHECK, IDLE. Then a back-to-back len=0 packet completes in 3 cycles with good_cnt=1.
- rst asserted mid-payload and a good packet sent afterwards -> counters 0 after reset, no err, next packet accepted normally. With CNT_W=2, four good packets -> good_cnt saturates at 3.

Source files
------------

// File: rtl/router_pkt_rx.sv
// router_pkt_rx: byte-serial packet receiver for the router source port.
// Parses the header (dest in the low ADDR_W bits, len above), steers every
// byte of a packet into the selected destination FIFO, checks the trailing
// parity byte, flags truncated and misaddressed packets, and keeps saturating
// good-packet and error counters.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pkt_valid         source has a packet byte on data_in
//   data_in           packet byte
//   fifo_full         per-channel destination FIFO full
//   busy              combinational back-pressure; source holds data_in
//   err               registered one-cycle error pulse
//   wr_en             one-hot FIFO write strobe (combinational)
//   wr_data           byte to write, equals data_in
//   good_cnt          saturating count of packets with correct parity
//   err_cnt           saturating count of error events
module router_pkt_rx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_full,
    output logic              busy,
    output logic              err,
    output logic [NUM_CH-1:0] wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned ADDR_W = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH);
    localparam int unsigned LEN_W  = DATA_W - ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_PARITY,
        ST_CHECK,
        ST_DROP
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  par_q, par_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   errc_q, errc_d;

    logic [ADDR_W-1:0]  hdr_dest;
    logic [LEN_W-1:0]   hdr_len;
    logic               hdr_ok;
    logic [ADDR_W-1:0]  sel_dest;
    logic [NUM_CH-1:0]  sel_oh;
    logic               full_sel;
    logic               accept;
    logic               in_body;
    logic               write_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hdr_dest = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];
    assign hdr_ok   = (32'(hdr_dest) < NUM_CH);
    assign in_body  = (state_q == ST_PAYLOAD) || (state_q == ST_PARITY);

    // Channel being addressed this cycle: the live header in IDLE, else the latched dest.
    // An out-of-range header dest yields an all-zero select, so it can neither stall nor write.
    always_comb begin
        sel_dest = (state_q == ST_IDLE) ? hdr_dest : dest_q;
        sel_oh   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel_oh[i] = (32'(sel_dest) == i);
        end
        full_sel = |(fifo_full & sel_oh);
    end

    // Back-pressure, acceptance and write strobe.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            ST_IDLE:               busy = pkt_valid & full_sel;
            ST_PAYLOAD, ST_PARITY: busy = full_sel;
            ST_CHECK:              busy = 1'b1;
            default:               busy = 1'b0;
        endcase
        if (rst) begin
            busy = 1'b1;
        end
        accept  = pkt_valid & ~busy;
        write_c = accept & (in_body | ((state_q == ST_IDLE) & hdr_ok));
        wr_en   = write_c ? sel_oh : '0;
    end

    assign wr_data = data_in;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        rem_d   = rem_q;
        par_d   = par_q;
        err_d   = 1'b0;
        good_d  = good_q;
        errc_d  = errc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        dest_d  = hdr_dest;
                        rem_d   = hdr_len;
                        par_d   = data_in;
                        state_d = (hdr_len != '0) ? ST_PAYLOAD : ST_PARITY;
                    end else begin
                        err_d   = 1'b1;
                        errc_d  = sat_inc(errc_q);
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    par_d = par_q ^ data_in;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_PARITY;
                    end
                end else if (!pkt_valid && !busy) begin
                    err_d   = 1'b1;
                    errc_d  = sat_inc(errc_q);
                    state_d = ST_CHECK;
                end
            end
            ST_PARITY: begin
                if (accept) begin
                    if (data_in != par_q) begin
                        err_d  = 1'b1;
                        errc_d = sat_inc(errc_q);
                    end else begin
                        good_d = sat_inc(good_q);
                    end
                    state_d = ST_CHECK;
                end else if (!pkt_valid && !busy) begin
                    err_d   = 1'b1;
                    errc_d  = sat_inc(errc_q);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (!pkt_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
            rem_q   <= '0;
            par_q   <= '0;
            err_q   <= 1'b0;
            good_q  <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            rem_q   <= rem_d;
            par_q   <= par_d;
            err_q   <= err_d;
            good_q  <= good_d;
            errc_q  <= errc_d;
        end
    end

    assign err      = err_q;
    assign good_cnt = good_q;
    assign err_cnt  = errc_q;

endmodule

// File: tb/tb_router_pkt_rx.sv
module tb_router_pkt_rx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_full;
    logic              busy;
    logic              err;
    logic [NUM_CH-1:0] wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  err_cnt;

    router_pkt_rx #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .busy(busy), .err(err), .wr_en(wr_en),
        .wr_data(wr_data), .good_cnt(good_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_err[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a byte and hold it until accepted; ch >= 0 queues the expected write.
    task automatic send(input logic [7:0] b, input int ch, input string name);
        int n;
        wr_t e;
        n = 0;
        pkt_valid = 1'b1;
        data_in   = b;
        if (ch >= 0) begin
            e.ch = ch;
            e.data = b;
            exp_wr.push_back(e);
        end
        @(negedge clk);
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            check({name, "_accept_timeout"}, 32'(busy), 32'(0));
        end
        check({name, "_stall"}, 32'(n), 32'(0));
        @(posedge clk);
        #1;
    endtask

    // Release pkt_valid for the CHECK cycle, which must show busy.
    task automatic after_pkt(input string name);
        pkt_valid = 1'b0;
        @(negedge clk);
        check({name, "_busy_check"}, 32'(busy), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pkt_valid = 1'b0;
        data_in   = '0;
        fifo_full = '0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_wr_en", 32'(wr_en), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_good_cnt", 32'(good_cnt), 32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        @(posedge clk);
        #1;
    endtask

    // hdr 0x11: dest 1, len 4; parity = 11^A1^B2^C3^D4 = 0x15
    task automatic pkt_dest1(input logic [7:0] par, input string name);
        send(8'h11, 1, name);
        send(8'hA1, 1, name);
        send(8'hB2, 1, name);
        send(8'hC3, 1, name);
        send(8'hD4, 1, name);
        send(par, 1, name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        pkt_valid = 1'b0;
        data_in   = '0;
        fifo_full = '0;

        // Monitor: pops expected writes and err pulses whenever the DUT shows one.
        fork
            forever begin
                @(negedge clk);
                if (wr_en != '0) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_wr_en", 32'(wr_en), 32'(0));
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        check("wr_en", 32'(wr_en), 32'(1) << e.ch);
                        check("wr_data", 32'(wr_data), 32'(e.data));
                    end
                end
                if (err === 1'b1) begin
                    if (exp_err.size() == 0) begin
                        check("unexpected_err", 32'(err), 32'(0));
                    end else begin
                        check("err_cycle", 32'(cyc), 32'(exp_err.pop_front()));
                    end
                end
            end
        join_none

        // Good packet to dest 1
        do_reset();
        pkt_dest1(8'h15, "good");
        after_pkt("good");
        check("good_good_cnt", 32'(good_cnt), 32'(1));
        check("good_err_cnt", 32'(err_cnt), 32'(0));

        // Corrupted parity byte
        do_reset();
        pkt_dest1(8'h14, "badpar");
        exp_err.push_back(cyc);
        after_pkt("badpar");
        check("badpar_err_cnt", 32'(err_cnt), 32'(1));
        check("badpar_good_cnt", 32'(good_cnt), 32'(0));

        // Stall on dest 2: hdr 0x0E (dest 2, len 3), parity 0E^10^20^30 = 0x0E
        do_reset();
        send(8'h0E, 2, "stall");
        send(8'h10, 2, "stall");
        begin
            wr_t e;
            e.ch = 2;
            e.data = 8'h20;
            exp_wr.push_back(e);
        end
        pkt_valid = 1'b1;
        data_in   = 8'h20;
        fifo_full = 3'b100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_busy", 32'(busy), 32'(1));
            check("stall_no_wr", 32'(wr_en), 32'(0));
            @(posedge clk);
            #1;
        end
        fifo_full = '0;
        send(8'h20, -1, "stall_release");
        send(8'h30, 2, "stall");
        send(8'h0E, 2, "stall");
        after_pkt("stall");
        check("stall_good_cnt", 32'(good_cnt), 32'(1));
        check("stall_err_cnt", 32'(err_cnt), 32'(0));

        // Misaddressed header 0x07 (dest 3): five bytes dropped
        do_reset();
        send(8'h07, -1, "drop");
        exp_err.push_back(cyc);
        send(8'hAA, -1, "drop");
        send(8'hBB, -1, "drop");
        send(8'hCC, -1, "drop");
        send(8'hDD, -1, "drop");
        pkt_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drop_err_cnt", 32'(err_cnt), 32'(1));
        send(8'h00, 0, "drop_next");
        send(8'h00, 0, "drop_next");
        after_pkt("drop_next");
        check("drop_next_good_cnt", 32'(good_cnt), 32'(1));

        // Truncation after 2 of 4 payload bytes, then back-to-back len=0 packet
        do_reset();
        send(8'h10, 0, "trunc");
        send(8'h01, 0, "trunc");
        send(8'h02, 0, "trunc");
        pkt_valid = 1'b0;
        @(negedge clk);
        check("trunc_busy_low", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        exp_err.push_back(cyc);
        @(negedge clk);
        check("trunc_busy_check", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
        send(8'h01, 1, "len0");
        send(8'h01, 1, "len0");
        after_pkt("len0");
        check("trunc_err_cnt", 32'(err_cnt), 32'(1));
        check("len0_good_cnt", 32'(good_cnt), 32'(1));

        // Reset mid-payload, then four good packets saturate a 2-bit counter
        do_reset();
        send(8'h11, 1, "midrst");
        send(8'hA1, 1, "midrst");
        rst       = 1'b1;
        pkt_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_good_cnt", 32'(good_cnt), 32'(0));
        check("midrst_err_cnt", 32'(err_cnt), 32'(0));
        @(posedge clk);
        #1;
        pkt_dest1(8'h15, "sat1");
        after_pkt("sat1");
        check("sat1_good_cnt", 32'(good_cnt), 32'(1));
        pkt_dest1(8'h15, "sat2");
        after_pkt("sat2");
        pkt_dest1(8'h15, "sat3");
        after_pkt("sat3");
        check("sat3_good_cnt", 32'(good_cnt), 32'(3));
        pkt_dest1(8'h15, "sat4");
        after_pkt("sat4");
        check("sat4_good_cnt", 32'(good_cnt), 32'(3));
        check("sat_err_cnt", 32'(err_cnt), 32'(0));

        pkt_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 32'(exp_wr.size()), 32'(0));
        check("pending_errs", 32'(exp_err.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
